pc_fetch_unit: RTL

- Parametrised program-counter and fetch-request generator for the RV32I core; it replaces the bare PC register.
- Drives a valid/ready fetch request to instruction memory and supports stall.
- Accepts branch, JALR and trap redirects, computing targets internally.
- Detects misaligned targets and holds a redirect pending while a fetch is stuck mid-handshake, so the request stays stable.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_target_calc.sv | 33 +++
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the PC / fetch-request generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JALR   = 2'd1,
    TRAP   = 2'd2
  } redirect_sel_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'hBFC0_0180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation with alignment check; misaligned
// targets are replaced by the trap vector, the raw value is kept for trap_epc.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int                  INSTR_BYTES = 4
) (
  input  logic [1:0]          sel,
  input  logic [PC_WIDTH-1:0] base,
  input  logic [PC_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0] raw_target,
  output logic [PC_WIDTH-1:0] target,
  output logic                misaligned
);

  logic [PC_WIDTH-1:0] sum;

  // Reserved select encoding falls into the default arm and behaves as TRAP.
  always_comb begin
    sum        = base + imm;
    raw_target = TRAP_VECTOR;
    case (sel)
      BRANCH:  raw_target = sum;
      JALR:    raw_target = {sum[PC_WIDTH-1:1], 1'b0};
      default: raw_target = TRAP_VECTOR;
    endcase
    misaligned = (INSTR_BYTES == 2) ? raw_target[0] : raw_target[1];
    target     = misaligned ? TRAP_VECTOR : raw_target;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and valid/ready fetch-request generator with redirects.
// Optional macro PC_PERF_EN adds saturating fetch/redirect performance counters.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int                  INSTR_BYTES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_kill,
  input  logic                redirect_en,
  input  logic [1:0]          redirect_sel,
  input  logic [PC_WIDTH-1:0] redirect_base,
  input  logic [PC_WIDTH-1:0] redirect_imm,
  output logic                misalign_err,
  output logic [PC_WIDTH-1:0] trap_epc
`ifdef PC_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_redirect_cnt
`endif
);

  pc_state_t           state;
  logic [PC_WIDTH-1:0] pend_target;
  logic [PC_WIDTH-1:0] raw_target;
  logic [PC_WIDTH-1:0] eff_target;
  logic                tgt_misaligned;
  logic                accept;

  assign accept     = fetch_valid && fetch_ready;
  assign fetch_kill = (state == PEND);

  pc_target_calc #(
    .PC_WIDTH    (PC_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_target_calc (
    .sel        (redirect_sel),
    .base       (redirect_base),
    .imm        (redirect_imm),
    .raw_target (raw_target),
    .target     (eff_target),
    .misaligned (tgt_misaligned)
  );

  // A redirect arriving mid-handshake is parked in pend_target so the request
  // on the bus stays stable until memory accepts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
      trap_epc     <= '0;
      pend_target  <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          if (!stall) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_en && fetch_valid && !fetch_ready) begin
            pend_target <= eff_target;
            state       <= PEND;
          end else if (redirect_en) begin
            pc          <= eff_target;
            fetch_valid <= !stall;
          end else if (accept) begin
            pc          <= pc + PC_WIDTH'(INSTR_BYTES);
            fetch_valid <= !stall;
          end else if (!fetch_valid) begin
            fetch_valid <= !stall;
          end
        end
        PEND: begin
          if (redirect_en && accept) begin
            pc          <= eff_target;
            fetch_valid <= !stall;
            state       <= RUN;
          end else if (redirect_en) begin
            pend_target <= eff_target;
          end else if (accept) begin
            pc          <= pend_target;
            fetch_valid <= !stall;
            state       <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
      if (redirect_en && state != BOOT) begin
        misalign_err <= tgt_misaligned;
        if (tgt_misaligned) trap_epc <= raw_target;
      end
    end
  end

`ifdef PC_PERF_EN
  // Saturating counters of accepted fetches and sampled redirects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (accept && perf_fetch_cnt != 32'hFFFF_FFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_en && perf_redirect_cnt != 32'hFFFF_FFFF)
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
